// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared constants for the generic JTAG TAP build: instruction codes,
// the 16 TAP state encodings (one-hot) and small helpers.
package jtag_tap_ctrl_pkg;

    // Instruction register width and instruction codes
    localparam int         IR_LENGTH   = 4;
    localparam logic [3:0] JTAG_IDCODE = 4'h1;
    localparam logic [3:0] JTAG_BYPASS = 4'hF;
    localparam logic [3:0] GPIO_CONFIG = 4'h2;
    localparam logic [3:0] GPIO_DATA   = 4'h3;

    // Bit positions of each TAP state inside the one-hot state vector
    localparam int TAP_IDX_TLR    = 0;
    localparam int TAP_IDX_RTI    = 1;
    localparam int TAP_IDX_SEL_DR = 2;
    localparam int TAP_IDX_CAP_DR = 3;
    localparam int TAP_IDX_SH_DR  = 4;
    localparam int TAP_IDX_EX1_DR = 5;
    localparam int TAP_IDX_PAU_DR = 6;
    localparam int TAP_IDX_EX2_DR = 7;
    localparam int TAP_IDX_UPD_DR = 8;
    localparam int TAP_IDX_SEL_IR = 9;
    localparam int TAP_IDX_CAP_IR = 10;
    localparam int TAP_IDX_SH_IR  = 11;
    localparam int TAP_IDX_EX1_IR = 12;
    localparam int TAP_IDX_PAU_IR = 13;
    localparam int TAP_IDX_EX2_IR = 14;
    localparam int TAP_IDX_UPD_IR = 15;

    // One-hot encoding: every strobe is a single register bit, so the
    // strobes cannot glitch when the state changes.
    typedef enum logic [15:0] {
        TAP_TLR    = 16'h0001,
        TAP_RTI    = 16'h0002,
        TAP_SEL_DR = 16'h0004,
        TAP_CAP_DR = 16'h0008,
        TAP_SH_DR  = 16'h0010,
        TAP_EX1_DR = 16'h0020,
        TAP_PAU_DR = 16'h0040,
        TAP_EX2_DR = 16'h0080,
        TAP_UPD_DR = 16'h0100,
        TAP_SEL_IR = 16'h0200,
        TAP_CAP_IR = 16'h0400,
        TAP_SH_IR  = 16'h0800,
        TAP_EX1_IR = 16'h1000,
        TAP_PAU_IR = 16'h2000,
        TAP_EX2_IR = 16'h4000,
        TAP_UPD_IR = 16'h8000
    } tap_state_e;

    // True when the one-hot state has the bit for state index idx set
    function automatic logic tap_in_state(input tap_state_e s, input int idx);
        return s[idx];
    endfunction

endpackage

// File: rtl/jtag_tap_ctrl_fsm.sv
// TAP state machine: decodes TMS into the 16-state IEEE 1149.1 controller.
module jtag_tap_fsm
    import jtag_tap_ctrl_pkg::*;
(
    input  logic       tck,
    input  logic       reset_,
    input  logic       tms,
    output tap_state_e state_o
);

    tap_state_e state_q;

    // State register with next-state decode; reset forces Test-Logic-Reset
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            state_q <= TAP_TLR;
        end else begin
            case (state_q)
                TAP_TLR:    state_q <= tms ? TAP_TLR    : TAP_RTI;
                TAP_RTI:    state_q <= tms ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR: state_q <= tms ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR: state_q <= tms ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:  state_q <= tms ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR: state_q <= tms ? TAP_UPD_DR : TAP_PAU_DR;
                TAP_PAU_DR: state_q <= tms ? TAP_EX2_DR : TAP_PAU_DR;
                TAP_EX2_DR: state_q <= tms ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR: state_q <= tms ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR: state_q <= tms ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR: state_q <= tms ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:  state_q <= tms ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR: state_q <= tms ? TAP_UPD_IR : TAP_PAU_IR;
                TAP_PAU_IR: state_q <= tms ? TAP_EX2_IR : TAP_PAU_IR;
                TAP_EX2_IR: state_q <= tms ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR: state_q <= tms ? TAP_SEL_DR : TAP_RTI;
                // Any corrupted (non one-hot) value recovers to TLR
                default:    state_q <= TAP_TLR;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: instruction register, IDCODE and BYPASS data
// registers, DR strobes for the user block and the TDO output mux.
// IR_BITS must be at least 2 and IDCODE_VALUE[0] must be 1.
module jtag_tap_ctrl
    import jtag_tap_ctrl_pkg::*;
#(
    parameter int          IR_BITS      = IR_LENGTH,
    parameter logic [31:0] IDCODE_VALUE = 32'h0BAD_C0DF
) (
    input  logic               tck,
    input  logic               reset_,
    input  logic               tms,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_oe,
    input  logic               user_tdo,
    output logic [IR_BITS-1:0] ir,
    output logic               capture_dr,
    output logic               shift_dr,
    output logic               update_dr
);

    // Instruction codes resized to the configured IR width
    localparam logic [IR_BITS-1:0] IR_IDCODE  = IR_BITS'(JTAG_IDCODE);
    localparam logic [IR_BITS-1:0] IR_BYPASS  = '1;
    localparam logic [IR_BITS-1:0] IR_CAPTURE = IR_BITS'(2'b01);

    tap_state_e state;

    logic [IR_BITS-1:0] ir_q, ir_d;
    logic [IR_BITS-1:0] ir_shift_q, ir_shift_d;
    logic [31:0]        idcode_q, idcode_d;
    logic               bypass_q, bypass_d;
    logic               tdo_q, tdo_d;
    logic               tdo_oe_q, tdo_oe_d;

    logic sel_idcode;
    logic sel_bypass;
    logic dr_tdo;

    jtag_tap_fsm u_fsm (
        .tck     (tck),
        .reset_  (reset_),
        .tms     (tms),
        .state_o (state)
    );

    // Strobes are single one-hot state bits, valid for the whole tck cycle
    assign capture_dr = tap_in_state(state, TAP_IDX_CAP_DR);
    assign shift_dr   = tap_in_state(state, TAP_IDX_SH_DR);
    assign update_dr  = tap_in_state(state, TAP_IDX_UPD_DR);

    // Data register selection follows the active instruction
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_bypass = (ir_q == IR_BYPASS);
    assign dr_tdo     = sel_idcode ? idcode_q[0] :
                        sel_bypass ? bypass_q    : user_tdo;

    // Next values of the rising-edge registers (IR, IR shifter, IDCODE, bypass)
    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;

        if (tap_in_state(state, TAP_IDX_TLR)) begin
            ir_d = IR_IDCODE;
        end
        if (tap_in_state(state, TAP_IDX_UPD_IR)) begin
            ir_d = ir_shift_q;
        end

        if (tap_in_state(state, TAP_IDX_CAP_IR)) begin
            ir_shift_d = IR_CAPTURE;
        end
        if (tap_in_state(state, TAP_IDX_SH_IR)) begin
            ir_shift_d = {tdi, ir_shift_q[IR_BITS-1:1]};
        end

        if (tap_in_state(state, TAP_IDX_CAP_DR)) begin
            if (sel_idcode) begin
                idcode_d = IDCODE_VALUE;
            end
            if (sel_bypass) begin
                bypass_d = 1'b0;
            end
        end
        if (tap_in_state(state, TAP_IDX_SH_DR)) begin
            if (sel_idcode) begin
                idcode_d = {tdi, idcode_q[31:1]};
            end
            if (sel_bypass) begin
                bypass_d = tdi;
            end
        end
    end

    // Rising-edge registers; reset discards any partial IR/DR contents
    always_ff @(posedge tck or negedge reset_) begin
        if (!reset_) begin
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    // TDO mux: drive the active shift register LSB, otherwise float and hold
    always_comb begin
        tdo_d    = tdo_q;
        tdo_oe_d = 1'b0;
        if (tap_in_state(state, TAP_IDX_SH_IR)) begin
            tdo_d    = ir_shift_q[0];
            tdo_oe_d = 1'b1;
        end else if (tap_in_state(state, TAP_IDX_SH_DR)) begin
            tdo_d    = dr_tdo;
            tdo_oe_d = 1'b1;
        end
    end

    // TDO registers launch on the falling edge so the target samples mid-cycle
    always_ff @(negedge tck or negedge reset_) begin
        if (!reset_) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo    = tdo_q;
    assign tdo_oe = tdo_oe_q;
    assign ir     = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scans from the test plan
// followed by randomized TMS/TDI traffic, all checked against a
// transition-table reference model.
module tb_jtag_tap_ctrl;
    import jtag_tap_ctrl_pkg::*;

    localparam logic [31:0] IDV = 32'h0BAD_C0DF;

    logic       tck = 1'b0;
    logic       reset_ = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       user_tdo = 1'b0;
    logic       tdo, tdo_oe, capture_dr, shift_dr, update_dr;
    logic [3:0] ir;

    int checks = 0;
    int errors = 0;

    jtag_tap_ctrl #(.IR_BITS(4), .IDCODE_VALUE(IDV)) dut (
        .tck        (tck),
        .reset_     (reset_),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_oe     (tdo_oe),
        .user_tdo   (user_tdo),
        .ir         (ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    always #5 tck = ~tck;

    // Reference model: states numbered in the order they are listed
    localparam int M_TLR = 0, M_RTI = 1, M_SEL_DR = 2, M_CAP_DR = 3, M_SH_DR = 4,
                   M_EX1_DR = 5, M_PAU_DR = 6, M_EX2_DR = 7, M_UPD_DR = 8,
                   M_SEL_IR = 9, M_CAP_IR = 10, M_SH_IR = 11, M_EX1_IR = 12,
                   M_PAU_IR = 13, M_EX2_IR = 14, M_UPD_IR = 15;
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_st;
    logic [3:0]  m_ir, m_irs;
    logic [31:0] m_idc;
    logic        m_byp, m_tdo, m_oe;

    int oe_cnt, cap_cnt, sh_cnt, upd_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_TLR; m_ir = 4'h1; m_irs = 4'h0; m_idc = 32'h0;
        m_byp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0;
    endtask

    task automatic model_rise(input logic t, input logic d);
        int s;
        s = m_st;
        case (s)
            M_TLR:    m_ir = 4'h1;
            M_UPD_IR: m_ir = m_irs;
            M_CAP_IR: m_irs = 4'b0001;
            M_SH_IR:  m_irs = (m_irs >> 1) | (4'(d) << 3);
            M_CAP_DR: begin
                if (m_ir == 4'h1) m_idc = IDV;
                else if (m_ir == 4'hF) m_byp = 1'b0;
            end
            M_SH_DR: begin
                if (m_ir == 4'h1) m_idc = (m_idc >> 1) | (32'(d) << 31);
                else if (m_ir == 4'hF) m_byp = d;
            end
            default: ;
        endcase
        m_st = t ? nxt1[s] : nxt0[s];
    endtask

    task automatic model_fall();
        if (m_st == M_SH_IR) begin
            m_tdo = m_irs[0]; m_oe = 1'b1;
        end else if (m_st == M_SH_DR) begin
            m_tdo = (m_ir == 4'h1) ? m_idc[0] : (m_ir == 4'hF) ? m_byp : user_tdo;
            m_oe = 1'b1;
        end else begin
            m_oe = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("tdo", 32'(tdo), 32'(m_tdo));
        check("tdo_oe", 32'(tdo_oe), 32'(m_oe));
        check("ir", 32'(ir), 32'(m_ir));
        check("capture_dr", 32'(capture_dr), 32'(m_st == M_CAP_DR));
        check("shift_dr", 32'(shift_dr), 32'(m_st == M_SH_DR));
        check("update_dr", 32'(update_dr), 32'(m_st == M_UPD_DR));
    endtask

    // One tck cycle: drive at negedge+1, model both edges, check at negedge+1
    task automatic step(input logic t, input logic d);
        tms = t; tdi = d; user_tdo = 1'($urandom_range(0, 1));
        @(posedge tck); model_rise(t, d);
        @(negedge tck); model_fall();
        #1;
        compare_all();
        oe_cnt  += int'(tdo_oe);
        cap_cnt += int'(capture_dr);
        sh_cnt  += int'(shift_dr);
        upd_cnt += int'(update_dr);
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge tck); #1;
        compare_all();
        reset_ = 1'b1;
    endtask

    // From RTI: scan IR with v, return the bits shifted out, end in RTI
    task automatic scan_ir(input logic [3:0] v, output logic [3:0] out);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            out[i] = tdo;
            step(i == 3, v[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: scan n DR bits of v, return the bits shifted out, end in RTI
    task automatic scan_dr(input int n, input logic [31:0] v, output logic [31:0] out);
        oe_cnt = 0; cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
        out = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            out[i] = tdo;
            step(i == n - 1, v[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    initial begin
        logic [3:0]  ir_out;
        logic [31:0] dr_out, v, exp_v;

        model_reset();
        @(negedge tck); #1;
        compare_all();
        check("reset_ir", 32'(ir), 32'(JTAG_IDCODE));
        reset_ = 1'b1;

        // Leave TLR
        step(0, 0);
        check("rti_oe", 32'(tdo_oe), 32'h0);

        // IDCODE readout
        scan_dr(32, 32'h0, dr_out);
        check("idcode_out", dr_out, 32'h0BAD_C0DF);
        check("idcode_oe_cnt", 32'(oe_cnt), 32'd32);
        check("idcode_cap_cnt", 32'(cap_cnt), 32'd1);
        check("idcode_upd_cnt", 32'(upd_cnt), 32'd1);

        // BYPASS: one-bit delay with a leading 0
        scan_ir(4'hF, ir_out);
        check("ir_capture_out", 32'(ir_out), 32'h1);
        check("ir_bypass", 32'(ir), 32'hF);
        v = 32'hA5;
        scan_dr(8, v, dr_out);
        exp_v = (v << 1) & 32'hFF;
        check("bypass_out", dr_out, exp_v);

        // User register: strobes and tdo following user_tdo
        scan_ir(GPIO_DATA, ir_out);
        check("ir_capture_out2", 32'(ir_out), 32'h1);
        check("ir_gpio", 32'(ir), 32'(GPIO_DATA));
        scan_dr(12, $urandom, dr_out);
        check("user_cap_cnt", 32'(cap_cnt), 32'd1);
        check("user_sh_cnt", 32'(sh_cnt), 32'd12);
        check("user_upd_cnt", 32'(upd_cnt), 32'd1);
        check("ir_stable", 32'(ir), 32'(GPIO_DATA));

        // Five TMS=1 edges from SH_DR reach TLR; one more edge in TLR reloads ir
        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(1, 0);
        check("tlr_ir", 32'(ir), 32'(JTAG_IDCODE));
        step(0, 0);

        // Async reset in the middle of an IR shift
        scan_ir(GPIO_DATA, ir_out);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
        do_reset();
        check("rst_oe", 32'(tdo_oe), 32'h0);
        check("rst_ir", 32'(ir), 32'(JTAG_IDCODE));
        step(0, 0);

        // IDCODE scan with a 10-cycle pause after bit 9
        v = $urandom;
        dr_out = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 32; i++) begin
            dr_out[i] = tdo;
            if (i == 9) begin
                step(1, v[i]);
                step(0, 0);
                for (int k = 0; k < 9; k++) step(0, 0);
                step(1, 0); step(0, 0);
            end else begin
                step(i == 31, v[i]);
            end
        end
        step(1, 0); step(0, 0);
        check("pause_idcode_out", dr_out, 32'h0BAD_C0DF);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
